parallel_to_serial: RTL and testbench
=====================================

Name: parallel_to_serial

Overview:
- Converts a `width`-bit parallel word into a stream of one-bit values, LSB first.
- Complements the serial-to-parallel converter in the same sequential-basics set.
- Upstream side is a valid/ready word interface.
- Downstream side is a valid/ready bit interface with a last-bit marker.
- Feeding its serial output into the serial-to-parallel converter (same `width`) must reproduce the original words.

Parameters:
- width, 8, bits per parallel word (legal: width >= 2).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (state cleared while rst == 0).
- parallel_valid  input  1  upstream word is present.
- parallel_data  input  width  upstream word.
- parallel_ready  output  1  block can accept a word this cycle.
- serial_valid  output  1  serial_data holds a valid bit.
- serial_data  output  1  current bit (word bit index = bit counter).
- serial_last  output  1  current bit is bit width-1 of the word.
- serial_ready  input  1  downstream consumes the bit this cycle.
- busy  output  1  a word is loaded and not fully sent.

Behaviour:
- State: IDLE / SHIFT.
  - shift register `sreg[width-1:0]`.
  - bit counter `cnt`, $clog2(width) bits.
- Transfer rules:
  - Word accepted on the clk edge where parallel_valid && parallel_ready.
  - Bit consumed on the edge where serial_valid && serial_ready.
- Reset (rst low, asynchronous), regardless of clk:
  - State IDLE, cnt = 0, sreg = 0.
  - serial_valid = 0, serial_data = 0, serial_last = 0, busy = 0.
  - Any partially sent word is discarded.
  - After rst rises, parallel_ready = 1 (IDLE).
- IDLE:
  - Outputs: parallel_ready = 1, serial_valid = 0, serial_data = 0, serial_last = 0, busy = 0.
  - On accept: sreg <= parallel_data, cnt <= 0, go to SHIFT.
- SHIFT:
  - Outputs: serial_valid = 1, busy = 1, serial_data = sreg[0], serial_last = (cnt == width-1).
  - On a consumed bit that is not last: sreg shifts right by one (zero fill), cnt <= cnt + 1.
  - On a consumed last bit with parallel_valid = 1: new word loaded, cnt <= 0, stay in SHIFT (no bubble).
  - On a consumed last bit with parallel_valid = 0: go to IDLE, cnt <= 0.
- parallel_ready:
  - = IDLE || (SHIFT && serial_last && serial_ready).
  - This is a combinational path from serial_ready; it is permitted and required for back-to-back operation.
- Latency:
  - Word accepted at edge N; bit 0 is on serial_data from edge N through the cycle before edge N+1 consumes it.
  - With serial_ready held at 1, one word occupies exactly width cycles.
  - Sustained throughput is one bit per cycle.
- Backpressure:
  - While serial_valid && !serial_ready, the block holds serial_data, serial_last, cnt and sreg stable.
  - serial_valid never drops mid-word.
- Input stability:
  - parallel_data is sampled only on the accept edge.
  - Changes to parallel_data at other times have no effect.
  - parallel_valid while busy and not on the last bit is ignored (parallel_ready = 0); upstream holds its word.
- Counter: cnt never exceeds width-1; it returns to 0 only via load or return to IDLE.
- Non-power-of-2 width: behaviour is identical (e.g. width = 5 sends 5 bits, last on cnt == 4).

Test Plan:
- Single word:
  - width = 8, serial_ready = 1, send 8'hA5.
  - serial_data over 8 cycles = 1,0,1,0,0,1,0,1.
  - serial_last only on the 8th bit; then serial_valid = 0, parallel_ready = 1.
- Back-to-back:
  - 8'h01 then 8'hFF with parallel_valid held, serial_ready = 1.
  - 16 consecutive serial_valid cycles with no gap: 1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1.
  - parallel_ready pulses on the cycle of the 8th bit.
- Backpressure:
  - Send 8'h3C; drop serial_ready for 3 cycles while bit 2 (value 1) is presented.
  - serial_data = 1 and cnt = 2 are held; the word completes in 11 cycles; the bit sequence is unchanged.
- Busy:
  - Present 8'h55 while 8'hAA is mid-transfer at bit 3.
  - parallel_ready = 0, 8'h55 is not loaded until the AA last bit.
  - Output stream: AA bits then 55 bits.
- Reset mid-word:
  - rst low asynchronously (between clk edges) after bit 4 of 8'hF0.
  - serial_valid and busy go 0 immediately.
  - After release, sending 8'h0F yields 1,1,1,1,0,0,0,0 from bit 0.
- Loopback:
  - 200 random words through this block into serial_to_parallel (width = 8), with random serial_ready gating applied to both sides' valid.
  - Every word is recovered in order, and the word count matches.

Source files
------------

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: word-to-bitstream converter, LSB first.
// Valid/ready word input, valid/ready bit output with last marker.
//
// Ports:
//   clk            clock, rising edge
//   rst            async reset, active low
//   parallel_valid upstream word present
//   parallel_data  upstream word
//   parallel_ready word can be taken this cycle
//   serial_valid   serial_data holds a valid bit
//   serial_data    current bit
//   serial_last    current bit is the word MSB
//   serial_ready   downstream takes the bit
//   busy           a word is loaded and not fully sent
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  input  logic             serial_ready,
  output logic             busy
);

  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_idx = cw'(width - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [width-1:0] sreg;
  logic [cw-1:0]    cnt;

  logic shifting;
  logic at_last;
  logic take_word;
  logic take_bit;

  assign shifting = (state == SHIFT);
  assign at_last  = shifting && (cnt == last_idx);

  assign serial_valid = shifting;
  assign serial_data  = shifting & sreg[0];
  assign serial_last  = at_last;
  assign busy         = shifting;

  // Ready on the last consumed bit lets the next word follow with no bubble.
  assign parallel_ready = !shifting || (at_last && serial_ready);

  assign take_word = parallel_valid && parallel_ready;
  assign take_bit  = shifting && serial_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (take_word) begin
      state <= SHIFT;
      sreg  <= parallel_data;
      cnt   <= '0;
    end else if (take_bit) begin
      if (at_last) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else begin
        sreg <= {1'b0, sreg[width-1:1]};
        cnt  <= cnt + cw'(1);
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: directed and random checks.
// Random phase decodes the bit stream back into words.
module tb_parallel_to_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pvalid = 1'b0;
  logic [W-1:0] pdata = '0;
  logic         pready;
  logic         svalid;
  logic         sdata;
  logic         slast;
  logic         sready = 1'b0;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;

  parallel_to_serial #(.width(W)) dut (
    .clk(clk),
    .rst(rst),
    .parallel_valid(pvalid),
    .parallel_data(pdata),
    .parallel_ready(pready),
    .serial_valid(svalid),
    .serial_data(sdata),
    .serial_last(slast),
    .serial_ready(sready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expect one full word with serial_ready held high.
  task automatic expect_word(input string tag,
                             input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      #1;
      chk({tag, " valid"}, 32'(svalid), 1);
      chk({tag, " data"}, 32'(sdata), 32'(w[i]));
      chk({tag, " last"}, 32'(slast), 32'(i == W - 1));
      chk({tag, " ready"}, 32'(pready), 32'(i == W - 1));
      tick();
    end
  endtask

  task automatic accept(input logic [W-1:0] w);
    pvalid = 1'b1;
    pdata  = w;
    tick();
    pvalid = 1'b0;
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc;
  logic [W-1:0] got;
  logic [W-1:0] ww;
  int bidx;
  int sent;
  int recv;
  int cyc;
  int vcyc;
  bit holding;

  initial begin
    // reset state
    sready = 1'b1;
    #2;
    chk("rst valid", 32'(svalid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst data", 32'(sdata), 0);
    chk("rst last", 32'(slast), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("idle ready", 32'(pready), 1);
    chk("idle valid", 32'(svalid), 0);

    // single word A5
    accept(8'hA5);
    expect_word("a5", 8'hA5);
    #1;
    chk("a5 end valid", 32'(svalid), 0);
    chk("a5 end ready", 32'(pready), 1);
    chk("a5 end busy", 32'(busy), 0);
    tick();

    // back-to-back 01 then FF
    pvalid = 1'b1;
    pdata  = 8'h01;
    tick();
    pdata = 8'hFF;
    for (int i = 0; i < 2 * W; i++) begin
      ww = (i < W) ? 8'h01 : 8'hFF;
      if (i == W) pvalid = 1'b0;
      #1;
      chk("b2b valid", 32'(svalid), 1);
      chk("b2b data", 32'(sdata), 32'(ww[i % W]));
      chk("b2b ready", 32'(pready), 32'(i % W == W - 1));
      tick();
    end
    #1;
    chk("b2b end valid", 32'(svalid), 0);
    tick();

    // backpressure on bit 2 of 3C
    accept(8'h3C);
    ww = 8'h3C;
    vcyc = 0;
    bidx = 0;
    while (bidx < W && vcyc < 40) begin
      sready = !(bidx == 2 && vcyc >= 2 && vcyc < 5);
      #1;
      chk("bp valid", 32'(svalid), 1);
      chk("bp data", 32'(sdata), 32'(ww[bidx]));
      chk("bp last", 32'(slast), 32'(bidx == W - 1));
      if (sready) bidx++;
      vcyc++;
      tick();
    end
    sready = 1'b1;
    chk("bp cycles", 32'(vcyc), 11);
    #1;
    chk("bp end valid", 32'(svalid), 0);
    tick();

    // upstream word offered while busy
    accept(8'hAA);
    ww = 8'hAA;
    for (int i = 0; i < W; i++) begin
      if (i == 3) begin
        pvalid = 1'b1;
        pdata  = 8'h55;
      end
      #1;
      chk("busy data", 32'(sdata), 32'(ww[i]));
      if (i >= 3) chk("busy ready", 32'(pready), 32'(i == W - 1));
      tick();
    end
    pvalid = 1'b0;
    pdata  = 8'h00;
    expect_word("busy 55", 8'h55);
    tick();

    // async reset mid-word
    accept(8'hF0);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst valid", 32'(svalid), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst data", 32'(sdata), 0);
    tick();
    rst = 1'b1;
    tick();
    accept(8'h0F);
    expect_word("after rst", 8'h0F);
    tick();

    // random loopback with decoder model
    sent = 0;
    recv = 0;
    bidx = 0;
    cyc = 0;
    holding = 0;
    acc = '0;
    while ((sent < 200 || recv < 200) && cyc < 20000) begin
      if (!holding) pvalid = 1'b0;
      if (!holding && sent < 200 && ($urandom % 2) == 0) begin
        pvalid  = 1'b1;
        pdata   = W'($urandom);
        holding = 1;
      end
      sready = ($urandom % 4) != 0;
      #1;
      if (bidx != 0) chk("lb no gap", 32'(svalid), 1);
      if (pvalid && pready) begin
        exp_q.push_back(pdata);
        sent++;
        holding = 0;
      end
      if (svalid && sready) begin
        acc[bidx] = sdata;
        chk("lb last", 32'(slast), 32'(bidx == W - 1));
        if (bidx == W - 1) begin
          if (exp_q.size() == 0) begin
            chk("lb underflow", 32'(exp_q.size()), 1);
          end else begin
            got = exp_q.pop_front();
            chk("lb word", 32'(acc), 32'(got));
          end
          recv++;
          bidx = 0;
        end else begin
          bidx++;
        end
      end
      cyc++;
      tick();
    end
    pvalid = 1'b0;
    chk("lb timeout", 32'(cyc < 20000), 1);
    chk("lb recv", 32'(recv), 200);
    chk("lb sent", 32'(sent), 200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
